result_uart_tx: RTL and testbench
=================================

Name: result_uart_tx

Overview:
- Consumer end of the CPU's 16-bit `result` bus.
- Captures result words on a valid strobe and buffers them in a small FIFO.
- Transmits each word as two UART frames (8N1, low byte first) so results can be observed off-chip on hardware.
- Sits beside the CPU at top level.

Parameters:
- DATA_W, 16, width of captured result word (fixed at 16; two bytes per word).
- FIFO_DEPTH, 8, FIFO entries; power of two, at least 2.
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- result_in  input  16  CPU result word.
- result_valid  input  1  one-cycle capture strobe; word is sampled on the same edge.
- ovf_clr  input  1  synchronous clear of the sticky overflow flag.
- tx  output  1  UART serial output; idles high.
- busy  output  1  high while a frame is in flight or the FIFO is non-empty.
- overflow  output  1  sticky; set when a word is dropped.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.

Behaviour:
- Reset (reset low, asynchronous): tx=1, busy=0, overflow=0, fifo_count=0, FSM=IDLE, FIFO pointers=0, baud counter=0.
- Release of reset is honoured on the next clock edge.
- Reset mid-frame aborts the frame immediately; tx goes high and all FIFO contents are discarded.
- Capture: result_valid=1 and FIFO not full pushes result_in on that edge.
- Full and pop in the same cycle: the push is accepted and the count is unchanged.
- Full and push without pop: the word is dropped and overflow is set on that edge.
- ovf_clr=1 clears overflow. If a drop and ovf_clr coincide, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty, pop the head word into a 16-bit shift register, select the low byte, and go to START on that edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - After the low byte: load the high byte and go to START with no gap.
    - After the high byte: go to IDLE.
- Between consecutive words, tx stays high for exactly one clock (the IDLE cycle).
- Latency: a word pushed into an empty FIFO on edge N is visible at edge N+1. IDLE pops on edge N+1, and tx falls on edge N+1.
- Word transmit time: 20*CLKS_PER_BIT cycles (22*CLKS_PER_BIT with parity).
- busy = (FSM != IDLE) | (fifo_count != 0), registered from next-state.
- Pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH and never underflows.

Optional Feature:
- Macro RESULT_UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving 11-bit frames.
- Undefined: no PARITY state; 8N1 frames exactly as above.

Test Plan:
- CLKS_PER_BIT=4, reset low for 3 cycles then high:
  - tx=1, busy=0, fifo_count=0, overflow=0 throughout.
  - No tx transition for 100 cycles.
- Single push of 0x12A5:
  - Start bit begins 1 edge after capture.
  - Frame 1 bits: 0, then 1,0,1,0,0,1,0,1, then 1.
  - Frame 2 bits: 0, then 0,1,0,0,1,0,0,0, then 1.
  - Each bit held 4 cycles; 80 cycles total; busy drops on the following edge.
- Push 0x0001 and 0xFFFF on consecutive cycles:
  - fifo_count peaks at 1 (first word popped immediately).
  - Exactly one idle-high cycle between word 1's last stop bit and word 2's start bit.
  - Decoded bytes in order: 01, 00, FF, FF.
- Push 10 words 0x0000..0x0009 on back-to-back cycles, FIFO_DEPTH=8:
  - Word 0 is popped and 8 are buffered; word 9 is dropped and overflow=1.
  - The serial stream carries words 0..8.
  - Pulse ovf_clr: overflow returns to 0.
- Assert reset during DATA of word 0x5555 with 3 words queued:
  - tx=1 and fifo_count=0 within the same cycle.
  - After release, no frame is emitted.
- With RESULT_UART_TX_PARITY_EN defined, push 0x0307:
  - Low frame 0x07 has parity bit 1; high frame 0x03 has parity bit 0.
  - Frames are 11 bits; word takes 88 cycles.

Source files
------------

// File: rtl/result_uart_tx.sv
// Result UART transmitter: captures 16-bit CPU result words into a FIFO and sends each as two UART frames, low byte first.
// Define RESULT_UART_TX_PARITY_EN to insert an even-parity bit into every frame (11-bit frames instead of 8N1).
module result_uart_tx #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            result_in,
  input  logic                         result_valid,
  input  logic                         ovf_clr,
  output logic                         tx,
  output logic                         busy,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned BAUD_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned CPB_LAST = CLKS_PER_BIT - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef RESULT_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [BAUD_W-1:0]   r_baud, w_baud_nxt;
  logic [2:0]          r_bit, w_bit_nxt;
  logic [DATA_W-1:0]   r_shift, w_shift_nxt;
  logic                r_hi, w_hi_nxt;
`ifdef RESULT_UART_TX_PARITY_EN
  logic                r_par, w_par_nxt;
`endif
  logic [PTR_W-1:0]    r_wr_ptr, w_wr_ptr_nxt;
  logic [PTR_W-1:0]    r_rd_ptr, w_rd_ptr_nxt;
  logic [CNT_W-1:0]    r_count, w_count_nxt;
  logic                r_tx, w_tx_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_ovf, w_ovf_nxt;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];

  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic                w_full;
  logic                w_baud_done;

  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_baud_done = (r_baud == BAUD_W'(CPB_LAST));

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign overflow   = r_ovf;
  assign fifo_count = r_count;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_hi     <= 1'b0;
`ifdef RESULT_UART_TX_PARITY_EN
      r_par    <= 1'b0;
`endif
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_baud   <= w_baud_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_hi     <= w_hi_nxt;
`ifdef RESULT_UART_TX_PARITY_EN
      r_par    <= w_par_nxt;
`endif
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_tx     <= w_tx_nxt;
      r_busy   <= w_busy_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  // FIFO storage needs no reset; pointers and count define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= result_in;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_baud_nxt   = r_baud;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_hi_nxt     = r_hi;
`ifdef RESULT_UART_TX_PARITY_EN
    w_par_nxt    = r_par;
`endif
    w_pop        = 1'b0;
    w_push       = 1'b0;
    w_drop       = 1'b0;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    w_tx_nxt     = 1'b1;
    w_busy_nxt   = 1'b0;
    w_ovf_nxt    = r_ovf;

    unique case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_hi_nxt    = 1'b0;
          w_baud_nxt  = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
`ifdef RESULT_UART_TX_PARITY_EN
          w_par_nxt   = 1'b0;
`endif
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      S_DATA: begin
        // The shift register walks through both bytes, so the high byte is in place after the low frame
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
`ifdef RESULT_UART_TX_PARITY_EN
          w_par_nxt   = r_par ^ r_shift[0];
`endif
          if (r_bit == 3'd7) begin
`ifdef RESULT_UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
`ifdef RESULT_UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_STOP;
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (!r_hi) begin
            w_hi_nxt    = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted
    w_push = result_valid && (!w_full || w_pop);
    w_drop = result_valid && w_full && !w_pop;

    if (w_push) w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
    if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);

    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase

    if (w_drop) begin
      w_ovf_nxt = 1'b1;
    end else if (ovf_clr) begin
      w_ovf_nxt = 1'b0;
    end

    unique case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef RESULT_UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = w_par_nxt;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: a word-level model predicts tx/busy/overflow/fifo_count every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_result_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 8;
`ifdef RESULT_UART_TX_PARITY_EN
  localparam int unsigned FRAME = 11;
`else
  localparam int unsigned FRAME = 10;
`endif
  localparam int unsigned WORD_CYC = 2 * FRAME * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        result_valid = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [15:0] result_in = '0;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [3:0]  fifo_count;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;
  int max_cnt = 0;

  result_uart_tx #(
    .DATA_W       (16),
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .result_in    (result_in),
    .result_valid (result_valid),
    .ovf_clr      (ovf_clr),
    .tx           (tx),
    .busy         (busy),
    .overflow     (overflow),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: a queue of pending words and the cycle offset into the word on the wire
  logic [15:0] m_q[$];
  int          m_phase = -1;
  logic [15:0] m_cur = '0;
  logic        m_ovf = 1'b0;
  bit          m_drop;

  function automatic logic exp_tx(input int phase, input logic [15:0] w);
    int b;
    int k;
    logic [7:0] by;
    if (phase < 0) return 1'b1;
    b  = phase / int'(CPB);
    by = (b < int'(FRAME)) ? w[7:0] : w[15:8];
    k  = b % int'(FRAME);
    if (k == 0) return 1'b0;
    if (k <= 8) return by[k-1];
    if (k == int'(FRAME) - 1) return 1'b1;
    return ^by;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_phase = -1;
      m_ovf   = 1'b0;
    end else begin
      m_drop = 1'b0;
      if (m_phase >= 0) begin
        m_phase++;
        if (m_phase == int'(WORD_CYC)) m_phase = -1;
      end else if (m_q.size() != 0) begin
        m_cur   = m_q.pop_front();
        m_phase = 0;
      end
      if (result_valid) begin
        if (m_q.size() < int'(DEPTH)) m_q.push_back(result_in);
        else m_drop = 1'b1;
      end
      if (m_drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("tx", 32'(tx), 32'(exp_tx(m_phase, m_cur)));
      chk("busy", 32'(busy), 32'((m_phase >= 0) || (m_q.size() != 0)));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end
  end

  task automatic rx_byte(output logic [7:0] b, output logic par, output logic stop);
    int t = 0;
    b = '0;
    par = 1'b0;
    stop = 1'b0;
    do begin
      @(negedge clk);
      t++;
    end while (tx !== 1'b0 && t < 3000);
    chk("rx_start_seen", 32'(tx), 32'd0);
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
`ifdef RESULT_UART_TX_PARITY_EN
    repeat (CPB) @(negedge clk);
    par = tx;
`endif
    repeat (CPB) @(negedge clk);
    stop = tx;
  endtask

  task automatic rx_word(output logic [15:0] w, output logic p_lo, output logic p_hi);
    logic [7:0] lo, hi;
    logic s;
    rx_byte(lo, p_lo, s);
    chk("stop_lo", 32'(s), 32'd1);
    rx_byte(hi, p_hi, s);
    chk("stop_hi", 32'(s), 32'd1);
    w = {hi, lo};
  endtask

`ifndef RESULT_UART_TX_PARITY_EN
  int unsigned exp_seq [20] = '{0,1,0,1,0,0,1,0,1,1, 0,0,1,0,0,1,0,0,0,1};
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic        pl, ph;
    int          cnt;

    // Reset held for three cycles, then idle for 100
    cmp_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
    end
    reset = 1'b1;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) cnt++;
    end
    chk("idle_100_cycles", 32'(cnt), 32'd0);

`ifndef RESULT_UART_TX_PARITY_EN
    // Single word 0x12A5: literal waveform, bit by bit
    @(negedge clk);
    result_in = 16'h12A5;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    chk("single_pre_start_tx", 32'(tx), 32'd1);
    chk("single_count", 32'(fifo_count), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    for (int j = 0; j < int'(WORD_CYC); j++) begin
      @(negedge clk);
      chk("single_wave", 32'(tx), 32'(exp_seq[j / int'(CPB)]));
    end
    @(negedge clk);
    chk("single_busy_drop", 32'(busy), 32'd0);
    chk("single_end_tx", 32'(tx), 32'd1);
`else
    // Parity build: 0x0307 gives parity 1 on 0x07 and 0 on 0x03, 88 busy cycles
    @(negedge clk);
    result_in = 16'h0307;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    fork
      begin
        rx_word(w, pl, ph);
        chk("par_word", 32'(w), 32'h0307);
        chk("par_lo_bit", 32'(pl), 32'd1);
        chk("par_hi_bit", 32'(ph), 32'd0);
      end
      begin
        cnt = 0;
        for (int j = 0; j < 200; j++) begin
          @(negedge clk);
          if (busy !== 1'b1) break;
          cnt++;
        end
        chk("par_word_cycles", 32'(cnt), 32'd88);
      end
    join
`endif
    repeat (5) @(negedge clk);

    // Two words on consecutive cycles: count peaks at 1, one idle cycle between words
    max_cnt = 0;
    fork
      begin
        @(negedge clk);
        result_valid = 1'b1;
        result_in = 16'h0001;
        @(negedge clk);
        result_in = 16'hFFFF;
        @(negedge clk);
        result_valid = 1'b0;
      end
      begin
        rx_word(w, pl, ph);
        chk("pair_word0", 32'(w), 32'h0001);
        cnt = 0;
        while (tx === 1'b1 && cnt < 100) begin
          @(negedge clk);
          if (tx === 1'b1) cnt++;
        end
        chk("pair_gap_negedges", 32'(cnt), 32'd2);
        rx_word(w, pl, ph);
        chk("pair_word1", 32'(w), 32'hFFFF);
      end
    join
    chk("pair_max_count", 32'(max_cnt), 32'd1);
    repeat (5) @(negedge clk);

    // Ten words back to back: word 9 dropped while ovf_clr is pulsed (set wins)
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          result_valid = 1'b1;
          result_in = 16'(i);
          ovf_clr = (i == 9);
        end
        @(negedge clk);
        result_valid = 1'b0;
        ovf_clr = 1'b0;
        chk("burst_overflow_set", 32'(overflow), 32'd1);
        chk("burst_count_full", 32'(fifo_count), 32'd8);
      end
      begin
        for (int i = 0; i < 9; i++) begin
          rx_word(w, pl, ph);
          chk("burst_word", 32'(w), 32'(i));
        end
      end
    join
    repeat (3) @(negedge clk);
    chk("burst_overflow_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("burst_overflow_cleared", 32'(overflow), 32'd0);
    repeat (5) @(negedge clk);

    // Reset during DATA of 0x5555 with three words queued
    @(negedge clk);
    result_valid = 1'b1;
    result_in = 16'h5555;
    @(negedge clk);
    result_in = 16'h1111;
    @(negedge clk);
    result_in = 16'h2222;
    @(negedge clk);
    result_in = 16'h3333;
    @(negedge clk);
    result_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_queued", 32'(fifo_count), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_count", 32'(fifo_count), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) cnt++;
    end
    chk("abort_no_frame", 32'(cnt), 32'd0);
    chk("abort_count_after", 32'(fifo_count), 32'd0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
